maxpool_window_ctrl: RTL and testbench

Sequencing controller that sits between the convolution output stream and the 2x2 max-pool datapath. It accepts one 16-bit feature-map pixel per valid cycle in raster order, buffers the even row of each row pair, and issues one packed 64-bit 2x2 window with stride 2 plus a valid strobe to the pooler. It also tracks frame position and signals end of frame.

---
 rtl/maxpool_pkg.sv | 19 +
 rtl/maxpool_line_buf.sv | 26 ++
 rtl/maxpool_window_ctrl.sv | 145 ++++++++++++++
 tb/tb_maxpool_window_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and constants for the 2x2 max-pool window controller.
package maxpool_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_WINDOW_WIDTH = 4 * DEFAULT_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2
  } state_t;

  // Lane positions inside the packed window, in units of one pixel.
  localparam int LANE_TL = 0;
  localparam int LANE_TR = 1;
  localparam int LANE_BL = 2;
  localparam int LANE_BR = 3;

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row line buffer: single write port, two combinational read ports, storage not reset.
module maxpool_line_buf #(
  parameter int DEPTH      = 26,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr0,
  input  logic [ADDR_W-1:0]     i_raddr1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata0 = mem[i_raddr0];
  assign o_rdata1 = mem[i_raddr1];

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Raster-stream to 2x2/stride-2 window sequencer for the max-pool datapath.
// Optional MAXPOOL_CTRL_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module maxpool_window_ctrl
  import maxpool_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 26,
  parameter int IMAGE_HEIGHT = 26,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]   i_pixel_data,
  input  logic                    i_pixel_valid,
  output logic [4*DATA_WIDTH-1:0] o_window_data,
  output logic                    o_window_valid,
  output logic                    o_frame_done,
  output logic                    o_busy
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
  ,
  output logic [7:0]              o_frame_count
`endif
);

  localparam int CW           = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW           = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int LAST_WIN_COL = 2 * (IMAGE_WIDTH / 2) - 1;
  localparam int LAST_WIN_ROW = 2 * (IMAGE_HEIGHT / 2) - 1;

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [DATA_WIDTH-1:0]   left_q, left_d;
  logic [4*DATA_WIDTH-1:0] window_q, window_d;
  logic                    win_vld_q, win_vld_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    end_of_row, last_row, buf_we;
  logic [DATA_WIDTH-1:0]   top_left, top_right;

  assign end_of_row = (col_q == CW'(IMAGE_WIDTH - 1));
  assign last_row   = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign buf_we     = i_pixel_valid && (state_q != ODD_ROW);

  // Windows only form at odd columns, so clearing bit 0 addresses col-1.
  maxpool_line_buf #(
    .DEPTH      (IMAGE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (CW)
  ) u_line_buf (
    .i_clk    (i_clk),
    .i_we     (buf_we),
    .i_waddr  (col_q),
    .i_wdata  (i_pixel_data),
    .i_raddr0 (col_q & ~CW'(1)),
    .i_raddr1 (col_q),
    .o_rdata0 (top_left),
    .o_rdata1 (top_right)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    left_d    = left_q;
    window_d  = window_q;
    win_vld_d = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    if (done_q) busy_d = 1'b0;
    if (i_pixel_valid) begin
      col_d = end_of_row ? '0 : col_q + 1'b1;
      if (end_of_row) row_d = last_row ? '0 : row_q + 1'b1;
      case (state_q)
        IDLE: begin
          state_d = EVEN_ROW;
          busy_d  = 1'b1;
        end
        EVEN_ROW: begin
          if (end_of_row) state_d = last_row ? IDLE : ODD_ROW;
        end
        ODD_ROW: begin
          if (!col_q[0]) begin
            left_d = i_pixel_data;
          end else begin
            window_d[LANE_TL*DATA_WIDTH +: DATA_WIDTH] = top_left;
            window_d[LANE_TR*DATA_WIDTH +: DATA_WIDTH] = top_right;
            window_d[LANE_BL*DATA_WIDTH +: DATA_WIDTH] = left_q;
            window_d[LANE_BR*DATA_WIDTH +: DATA_WIDTH] = i_pixel_data;
            win_vld_d = 1'b1;
            done_d    = (col_q == CW'(LAST_WIN_COL)) && (row_q == RW'(LAST_WIN_ROW));
          end
          if (end_of_row) state_d = last_row ? IDLE : EVEN_ROW;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      window_q  <= '0;
      win_vld_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      window_q  <= window_d;
      win_vld_q <= win_vld_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Bottom-left holding register is pure data and needs no reset.
  always_ff @(posedge i_clk) begin
    left_q <= left_d;
  end

  assign o_window_data  = window_q;
  assign o_window_valid = win_vld_q;
  assign o_frame_done   = done_q;
  assign o_busy         = busy_q;

`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (done_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) frame_cnt_q <= '0;
    else            frame_cnt_q <= frame_cnt_d;
  end

  assign o_frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Self-checking bench for maxpool_window_ctrl: 4x4, 5x5 and 26x26 instances.
module tb_maxpool_window_ctrl;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] pd [3];
  logic          pv [3];
  logic [4*DW-1:0] wd [3];
  logic          wv [3];
  logic          fd [3];
  logic          bz [3];
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
  logic [7:0]    fc [3];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  maxpool_window_ctrl #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .DATA_WIDTH(DW)) u_dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pixel_data(pd[0]), .i_pixel_valid(pv[0]),
    .o_window_data(wd[0]), .o_window_valid(wv[0]), .o_frame_done(fd[0]), .o_busy(bz[0])
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
    , .o_frame_count(fc[0])
`endif
  );

  maxpool_window_ctrl #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .DATA_WIDTH(DW)) u_dut5 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pixel_data(pd[1]), .i_pixel_valid(pv[1]),
    .o_window_data(wd[1]), .o_window_valid(wv[1]), .o_frame_done(fd[1]), .o_busy(bz[1])
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
    , .o_frame_count(fc[1])
`endif
  );

  maxpool_window_ctrl #(.IMAGE_WIDTH(26), .IMAGE_HEIGHT(26), .DATA_WIDTH(DW)) u_dut26 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pixel_data(pd[2]), .i_pixel_valid(pv[2]),
    .o_window_data(wd[2]), .o_window_valid(wv[2]), .o_frame_done(fd[2]), .o_busy(bz[2])
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
    , .o_frame_count(fc[2])
`endif
  );

  // Captured windows and, per frame-done pulse, the window count at that moment (-1 if no window).
  logic [4*DW-1:0] wq0[$], wq1[$], wq2[$];
  int dq0[$], dq1[$], dq2[$];

  always @(negedge clk) begin
    if (wv[0]) wq0.push_back(wd[0]);
    if (fd[0]) dq0.push_back(wv[0] ? wq0.size() : -1);
    if (wv[1]) wq1.push_back(wd[1]);
    if (fd[1]) dq1.push_back(wv[1] ? wq1.size() : -1);
    if (wv[2]) wq2.push_back(wd[2]);
    if (fd[2]) dq2.push_back(wv[2] ? wq2.size() : -1);
  end

  function automatic logic [4*DW-1:0] win(int tl, int tr, int bl, int br);
    return {DW'(br), DW'(bl), DW'(tr), DW'(tl)};
  endfunction

  // Reference: windows in raster order of window positions, straight from the image.
  function automatic void model(input int w, input int h, input logic [DW-1:0] px[$],
                                inout logic [4*DW-1:0] exp[$]);
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++)
        exp.push_back(win(px[(2*r)*w + 2*c], px[(2*r)*w + 2*c + 1],
                          px[(2*r+1)*w + 2*c], px[(2*r+1)*w + 2*c + 1]));
  endfunction

  task automatic chk(string name, logic [4*DW-1:0] act, logic [4*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_q(string name, input logic [4*DW-1:0] got[$], input logic [4*DW-1:0] exp[$]);
    chk({name, " count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s win%0d", name, i), got[i], exp[i]);
  endtask

  task automatic chk_done(string name, input int got[$], input int exp[$]);
    chk({name, " done pulses"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s done%0d at window", name, i), 64'(got[i]), 64'(exp[i]));
  endtask

  // Called in the phase just after a rising edge; returns in the same phase one cycle later.
  task automatic push_px(int k, logic [DW-1:0] d, logic v);
    pd[k] = d;
    pv[k] = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < 3; k++) pv[k] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_q();
    wq0.delete(); wq1.delete(); wq2.delete();
    dq0.delete(); dq1.delete(); dq2.delete();
  endtask

  typedef struct {
    logic [DW-1:0]   data;
    logic            exp_vld;
    logic [4*DW-1:0] exp_win;
    logic            exp_done;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [DW-1:0]   px[$];
    logic [4*DW-1:0] exp[$];
    int              dexp[$];

    for (int i = 0; i < 16; i++) tbl[i] = '{DW'(i + 1), 1'b0, '0, 1'b0};
    tbl[5]  = '{DW'(6),  1'b1, win(1, 2, 5, 6),     1'b0};
    tbl[7]  = '{DW'(8),  1'b1, win(3, 4, 7, 8),     1'b0};
    tbl[13] = '{DW'(14), 1'b1, win(9, 10, 13, 14),  1'b0};
    tbl[15] = '{DW'(16), 1'b1, win(11, 12, 15, 16), 1'b1};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin pd[k] = '0; pv[k] = 1'b0; end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset wdata%0d", k), wd[k], '0);
      chk($sformatf("reset wvalid%0d", k), 64'(wv[k]), 64'(0));
      chk($sformatf("reset done%0d", k), 64'(fd[k]), 64'(0));
      chk($sformatf("reset busy%0d", k), 64'(bz[k]), 64'(0));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // 4x4, continuous valid, checked cycle by cycle
    for (int i = 0; i < 16; i++) begin
      push_px(0, tbl[i].data, 1'b1);
      chk($sformatf("t4 vld%0d", i), 64'(wv[0]), 64'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) chk($sformatf("t4 win%0d", i), wd[0], tbl[i].exp_win);
      chk($sformatf("t4 done%0d", i), 64'(fd[0]), 64'(tbl[i].exp_done));
      if (i == 2) chk("t4 busy mid", 64'(bz[0]), 64'(1));
    end
    idle(1);
    chk("t4 busy after", 64'(bz[0]), 64'(0));
    chk("t4 vld after", 64'(wv[0]), 64'(0));
    chk("t4 hold", wd[0], win(11, 12, 15, 16));
    idle(2);

    // 5x5: last column and last row never windowed
    clear_q();
    for (int i = 1; i <= 25; i++) push_px(1, DW'(i), 1'b1);
    idle(3);
    exp = '{win(1, 2, 6, 7), win(3, 4, 8, 9), win(11, 12, 16, 17), win(13, 14, 18, 19)};
    chk_q("t5", wq1, exp);
    dexp = '{4};
    chk_done("t5", dq1, dexp);
    chk("t5 busy after", 64'(bz[1]), 64'(0));

    // 26x26 with random gaps against the model
    clear_q();
    px.delete(); exp.delete();
    for (int i = 0; i < 26 * 26; i++) px.push_back(DW'($urandom));
    for (int i = 0; i < 26 * 26; i++) begin
      while ($urandom_range(0, 9) < 3) push_px(2, DW'($urandom), 1'b0);
      push_px(2, px[i], 1'b1);
    end
    idle(3);
    model(26, 26, px, exp);
    chk_q("t26", wq2, exp);
    dexp = '{169};
    chk_done("t26", dq2, dexp);
    chk("t26 busy after", 64'(bz[2]), 64'(0));

    // Reset in the middle of the odd row, then a fresh frame
    for (int i = 1; i <= 7; i++) push_px(0, DW'(i), 1'b1);
    pv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst wdata", wd[0], '0);
    chk("midrst busy", 64'(bz[0]), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    px.delete(); exp.delete();
    for (int i = 0; i < 16; i++) px.push_back(DW'(101 + i));
    for (int i = 0; i < 16; i++) push_px(0, px[i], 1'b1);
    idle(3);
    model(4, 4, px, exp);
    chk_q("midrst", wq0, exp);
    dexp = '{4};
    chk_done("midrst", dq0, dexp);

    // Two 4x4 frames back to back, no dead cycle
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    px.delete(); exp.delete();
    for (int i = 0; i < 32; i++) px.push_back(DW'(201 + i));
    for (int i = 0; i < 32; i++) begin
      push_px(0, px[i], 1'b1);
      if (i == 17) chk("b2b busy frame2", 64'(bz[0]), 64'(1));
    end
    idle(3);
    model(4, 4, px[0:15], exp);
    model(4, 4, px[16:31], exp);
    chk_q("b2b", wq0, exp);
    dexp = '{4, 8};
    chk_done("b2b", dq0, dexp);
`ifdef MAXPOOL_CTRL_FRAME_CNT_EN
    chk("b2b frame count", 64'(fc[0]), 64'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
